// File: rtl/zmod_rx_align.sv
// Receive eye-training controller: sweeps a shared IDELAY tap, scores the nibble ramp, locks on the widest window centre.
// Define ZMOD_ALIGN_ERRCNT_EN to enable LOCKED-mode error counting and automatic retraining at ERR_THRESH.

module zmod_rx_align #(
   parameter int TAP_W      = 9,
   parameter int TAP_MAX    = 511,
   parameter int TAP_STEP   = 8,
   parameter int SETTLE_CYC = 16,
   parameter int CHECK_LEN  = 256,
   parameter int MIN_WIDTH  = 4,
   parameter int ERR_THRESH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       rx_data,
   output logic [TAP_W-1:0] tap_value,
   output logic             tap_load,
   output logic             busy,
   output logic             locked,
   output logic             fail,
   output logic [TAP_W-1:0] eye_start,
   output logic [7:0]       eye_width,
   output logic [15:0]      err_count
);

`ifdef ZMOD_ALIGN_ERRCNT_EN
   localparam bit ERRCNT_EN = 1'b1;
`else
   localparam bit ERRCNT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE, LOAD, SETTLE, CHECK, NEXT, CENTER, LOCKED, FAIL
   } state_t;

   state_t           state_q, state_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [TAP_W-1:0] tap_value_q, tap_value_d;
   logic             tap_load_q, tap_load_d;
   logic             busy_q, busy_d;
   logic             locked_q, locked_d;
   logic             fail_q, fail_d;
   logic [TAP_W-1:0] eye_start_q, eye_start_d;
   logic [7:0]       eye_width_q, eye_width_d;
   logic [15:0]      err_count_q, err_count_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [3:0]       prev_q, prev_d;
   logic             pt_err_q, pt_err_d;
   logic [TAP_W-1:0] cur_start_q, cur_start_d;
   logic [7:0]       cur_len_q, cur_len_d;
   logic [TAP_W-1:0] best_start_q, best_start_d;
   logic [7:0]       best_len_q, best_len_d;

   logic             train_go, train_full;
   logic             mismatch;
   logic [3:0]       prev_inc;
   logic [TAP_W:0]   tap_next;
   logic [TAP_W+7:0] span;
   logic [TAP_W-1:0] centre_tap;

   assign prev_inc   = prev_q + 4'd1;
   assign mismatch   = (rx_data != prev_inc);
   assign tap_next   = {1'b0, tap_q} + (TAP_W+1)'(TAP_STEP);
   // Centre offset is half the window span; computed wide so the product cannot wrap before truncation.
   assign span       = ((TAP_W+8)'(best_len_q) - (TAP_W+8)'(1)) * (TAP_W+8)'(TAP_STEP);
   assign centre_tap = TAP_W'((TAP_W+8)'(best_start_q) + (span >> 1));

   always_comb begin
      state_d      = state_q;
      tap_d        = tap_q;
      tap_value_d  = tap_value_q;
      tap_load_d   = 1'b0;
      eye_start_d  = eye_start_q;
      eye_width_d  = eye_width_q;
      err_count_d  = err_count_q;
      cnt_d        = cnt_q;
      prev_d       = rx_data;
      pt_err_d     = pt_err_q;
      cur_start_d  = cur_start_q;
      cur_len_d    = cur_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      train_go     = 1'b0;
      train_full   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               train_go   = 1'b1;
               train_full = 1'b1;
            end
         end
         LOAD: begin
            state_d  = SETTLE;
            cnt_d    = '0;
            pt_err_d = 1'b0;
         end
         SETTLE: begin
            if (cnt_q == 16'(SETTLE_CYC - 1)) begin
               state_d = CHECK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         CHECK: begin
            // Count zero only seeds prev; the following CHECK_LEN cycles are scored.
            if (cnt_q != 16'd0 && mismatch) pt_err_d = 1'b1;
            if (cnt_q == 16'(CHECK_LEN)) begin
               state_d = NEXT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         NEXT: begin
            if (!pt_err_q) begin
               if (cur_len_q == 8'd0) cur_start_d = tap_q;
               cur_len_d = cur_len_q + 8'd1;
            end else begin
               if (cur_len_q > best_len_q) begin
                  best_len_d   = cur_len_q;
                  best_start_d = cur_start_q;
               end
               cur_len_d = 8'd0;
            end
            if (tap_next <= (TAP_W+1)'(TAP_MAX)) begin
               tap_d       = tap_next[TAP_W-1:0];
               tap_value_d = tap_next[TAP_W-1:0];
               tap_load_d  = 1'b1;
               state_d     = LOAD;
            end else begin
               // Sweep exhausted: a window still open at the top tap competes too.
               if (cur_len_d > best_len_d) begin
                  best_len_d   = cur_len_d;
                  best_start_d = cur_start_d;
               end
               cur_len_d = 8'd0;
               state_d   = CENTER;
            end
         end
         CENTER: begin
            tap_load_d  = 1'b1;
            eye_width_d = best_len_q;
            if (best_len_q >= 8'(MIN_WIDTH)) begin
               tap_d       = centre_tap;
               tap_value_d = centre_tap;
               eye_start_d = best_start_q;
               state_d     = LOCKED;
            end else begin
               tap_d       = '0;
               tap_value_d = '0;
               state_d     = FAIL;
            end
         end
         LOCKED: begin
            if (start) begin
               train_go   = 1'b1;
               train_full = 1'b1;
            end else if (ERRCNT_EN) begin
               if (err_count_q >= 16'(ERR_THRESH)) begin
                  train_go = 1'b1;
               end else if (mismatch && err_count_q != 16'hFFFF) begin
                  err_count_d = err_count_q + 16'd1;
               end
            end
         end
         FAIL: begin
            if (start) begin
               train_go   = 1'b1;
               train_full = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Shared entry into a fresh sweep; an error-driven retrain keeps the last reported eye.
      if (train_go) begin
         state_d      = LOAD;
         tap_d        = '0;
         tap_value_d  = '0;
         tap_load_d   = 1'b1;
         cnt_d        = '0;
         pt_err_d     = 1'b0;
         cur_start_d  = '0;
         cur_len_d    = 8'd0;
         best_start_d = '0;
         best_len_d   = 8'd0;
         err_count_d  = 16'd0;
         if (train_full) begin
            eye_start_d = '0;
            eye_width_d = 8'd0;
         end
      end

      busy_d   = (state_d inside {LOAD, SETTLE, CHECK, NEXT, CENTER});
      locked_d = (state_d == LOCKED);
      fail_d   = (state_d == FAIL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         tap_q        <= '0;
         tap_value_q  <= '0;
         tap_load_q   <= 1'b0;
         busy_q       <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
         eye_start_q  <= '0;
         eye_width_q  <= 8'd0;
         err_count_q  <= 16'd0;
         cnt_q        <= '0;
         prev_q       <= 4'd0;
         pt_err_q     <= 1'b0;
         cur_start_q  <= '0;
         cur_len_q    <= 8'd0;
         best_start_q <= '0;
         best_len_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         tap_q        <= tap_d;
         tap_value_q  <= tap_value_d;
         tap_load_q   <= tap_load_d;
         busy_q       <= busy_d;
         locked_q     <= locked_d;
         fail_q       <= fail_d;
         eye_start_q  <= eye_start_d;
         eye_width_q  <= eye_width_d;
         err_count_q  <= err_count_d;
         cnt_q        <= cnt_d;
         prev_q       <= prev_d;
         pt_err_q     <= pt_err_d;
         cur_start_q  <= cur_start_d;
         cur_len_q    <= cur_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
      end
   end

   assign tap_value = tap_value_q;
   assign tap_load  = tap_load_q;
   assign busy      = busy_q;
   assign locked    = locked_q;
   assign fail      = fail_q;
   assign eye_start = eye_start_q;
   assign eye_width = eye_width_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_zmod_rx_align.sv
// Directed bench for zmod_rx_align; models the delay line and a tap-dependent nibble ramp.
// Short SETTLE_CYC/CHECK_LEN keep full sweeps cheap; tap geometry uses the default values.

module tb_zmod_rx_align;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] rx_data;
   logic [8:0] tap_value;
   logic       tap_load;
   logic       busy;
   logic       locked;
   logic       fail;
   logic [8:0] eye_start;
   logic [7:0] eye_width;
   logic [15:0] err_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   mode     = 0;
   int   inject   = 0;
   int   dly_tap  = 0;
   logic [3:0] pat = 4'd0;
   int   load_log[$];

   zmod_rx_align #(
      .TAP_W(9), .TAP_MAX(511), .TAP_STEP(8), .SETTLE_CYC(2), .CHECK_LEN(8),
      .MIN_WIDTH(4), .ERR_THRESH(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rx_data(rx_data),
      .tap_value(tap_value), .tap_load(tap_load), .busy(busy), .locked(locked),
      .fail(fail), .eye_start(eye_start), .eye_width(eye_width), .err_count(err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Which delay taps see a clean ramp in the current scenario.
   function automatic bit tap_good(input int t);
      case (mode)
         0:       return 1'b1;
         1:       return (t >= 128 && t <= 256);
         2:       return ((t >= 64 && t <= 120) || (t >= 320 && t <= 376));
         default: return 1'b0;
      endcase
   endfunction

   // Observe at the falling edge, latch any tap load into the delay model, then drive the next nibble.
   task automatic tick();
      @(negedge clk);
      if (tap_load) begin
         load_log.push_back(int'(tap_value));
         dly_tap = int'(tap_value);
      end
      if (inject > 0) inject--;
      else if (tap_good(dly_tap)) pat = pat + 4'd1;
      rx_data = pat;
   endtask

   task automatic start_train();
      load_log.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (tap_load !== 1'b1) begin n_fail++; $display("[TB] FAIL start_latency_load: got %0b, expected 1", tap_load); end
      n_checks++; if (tap_value !== 9'd0) begin n_fail++; $display("[TB] FAIL start_tap0: got %0d, expected 0", tap_value); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL start_busy: got %0b, expected 1", busy); end
   endtask

   task automatic wait_train();
      for (int i = 0; i < 3000; i++) begin
         if (!busy && (locked || fail)) return;
         tick();
      end
      n_checks++; n_fail++;
      $display("[TB] FAIL train_timeout: busy=%0b locked=%0b fail=%0b, expected training to finish", busy, locked, fail);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; rx_data = 4'd0;
      repeat (3) tick();
      n_checks++; if (tap_value !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_tap_value: got %0d, expected 0", tap_value); end
      n_checks++; if (tap_load !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tap_load: got %0b, expected 0", tap_load); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_locked: got %0b, expected 0", locked); end
      n_checks++; if (fail !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fail: got %0b, expected 0", fail); end
      n_checks++; if (eye_start !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_eye_start: got %0d, expected 0", eye_start); end
      n_checks++; if (eye_width !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_eye_width: got %0d, expected 0", eye_width); end
      n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_err_count: got %0d, expected 0", err_count); end
      rst = 1'b0;
      repeat (2) tick();
      n_checks++; if (busy !== 1'b0 || tap_load !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_hold: busy=%0b tap_load=%0b, expected 0/0", busy, tap_load); end
   endtask

   task automatic test_clean_sweep();
      mode = 0;
      start_train();
      wait_train();
      n_checks++;
      if (load_log.size() !== 65) begin
         n_fail++; $display("[TB] FAIL clean_load_count: got %0d, expected 65", load_log.size());
      end else begin
         for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (load_log[i] !== i * 8) begin n_fail++; $display("[TB] FAIL clean_sweep_tap[%0d]: got %0d, expected %0d", i, load_log[i], i * 8); end
         end
         n_checks++; if (load_log[64] !== 252) begin n_fail++; $display("[TB] FAIL clean_centre_load: got %0d, expected 252", load_log[64]); end
      end
      n_checks++; if (tap_value !== 9'd252) begin n_fail++; $display("[TB] FAIL clean_tap_value: got %0d, expected 252", tap_value); end
      n_checks++; if (eye_start !== 9'd0) begin n_fail++; $display("[TB] FAIL clean_eye_start: got %0d, expected 0", eye_start); end
      n_checks++; if (eye_width !== 8'd64) begin n_fail++; $display("[TB] FAIL clean_eye_width: got %0d, expected 64", eye_width); end
      n_checks++; if (locked !== 1'b1 || fail !== 1'b0) begin n_fail++; $display("[TB] FAIL clean_flags: locked=%0b fail=%0b, expected 1/0", locked, fail); end
   endtask

   task automatic test_single_window();
      mode = 1;
      start_train();
      wait_train();
      n_checks++; if (load_log.size() == 0 || load_log[$] !== 192) begin n_fail++; $display("[TB] FAIL win_centre_load: got %0d, expected 192", tap_value); end
      n_checks++; if (eye_start !== 9'd128) begin n_fail++; $display("[TB] FAIL win_eye_start: got %0d, expected 128", eye_start); end
      n_checks++; if (eye_width !== 8'd17) begin n_fail++; $display("[TB] FAIL win_eye_width: got %0d, expected 17", eye_width); end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL win_locked: got %0b, expected 1", locked); end
   endtask

   task automatic test_two_windows();
      mode = 2;
      start_train();
      wait_train();
      n_checks++; if (load_log.size() == 0 || load_log[$] !== 92) begin n_fail++; $display("[TB] FAIL tie_centre_load: got %0d, expected 92", tap_value); end
      n_checks++; if (eye_start !== 9'd64) begin n_fail++; $display("[TB] FAIL tie_eye_start: got %0d, expected 64", eye_start); end
      n_checks++; if (eye_width !== 8'd8) begin n_fail++; $display("[TB] FAIL tie_eye_width: got %0d, expected 8", eye_width); end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL tie_locked: got %0b, expected 1", locked); end
   endtask

   task automatic test_no_window();
      mode = 3;
      start_train();
      wait_train();
      n_checks++; if (load_log.size() !== 65) begin n_fail++; $display("[TB] FAIL nowin_load_count: got %0d, expected 65", load_log.size()); end
      n_checks++; if (load_log.size() == 0 || load_log[$] !== 0) begin n_fail++; $display("[TB] FAIL nowin_final_load: got %0d, expected 0", tap_value); end
      n_checks++; if (fail !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("[TB] FAIL nowin_flags: fail=%0b locked=%0b, expected 1/0", fail, locked); end
      n_checks++; if (eye_width !== 8'd0) begin n_fail++; $display("[TB] FAIL nowin_eye_width: got %0d, expected 0", eye_width); end
   endtask

   task automatic test_locked_errors();
      bit seen;
      mode = 0;
      start_train();
      wait_train();
      n_checks++; if (locked !== 1'b1 || err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL lock_pre_inject: locked=%0b err=%0d, expected 1/0", locked, err_count); end
      inject = 16;
`ifdef ZMOD_ALIGN_ERRCNT_EN
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (err_count == 16'd16) seen = 1'b1;
      end
      n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL err_reach_thresh: got %0d, expected 16", err_count); end
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL err_locked_at_thresh: got %0b, expected 1", locked); end
      tick();
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL err_locked_drop: got %0b, expected 0", locked); end
      n_checks++; if (tap_load !== 1'b1 || tap_value !== 9'd0) begin n_fail++; $display("[TB] FAIL err_retrain_load: load=%0b tap=%0d, expected 1/0", tap_load, tap_value); end
      load_log.delete();
      wait_train();
      n_checks++; if (locked !== 1'b1 || load_log.size() == 0 || load_log[$] !== 252) begin n_fail++; $display("[TB] FAIL err_relock: locked=%0b tap=%0d, expected 1/252", locked, tap_value); end
`else
      seen = 1'b0;
      repeat (40) tick();
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL noerr_locked: got %0b, expected 1", locked); end
      n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL noerr_err_count: got %0d, expected 0", err_count); end
      n_checks++; if (busy !== 1'b0 || seen) begin n_fail++; $display("[TB] FAIL noerr_busy: got %0b, expected 0", busy); end
`endif
   endtask

   task automatic test_rst_mid_sweep();
      bit hit;
      mode = 0;
      start_train();
      repeat (20) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 1500 && !hit; i++) begin
         tick();
         if (load_log.size() > 0 && load_log[$] == 200) hit = 1'b1;
      end
      n_checks++; if (!hit) begin n_fail++; $display("[TB] FAIL rst_reach_tap200: got %0d, expected 200", tap_value); end
      n_checks++; if (load_log.size() !== 26) begin n_fail++; $display("[TB] FAIL busy_start_ignored: got %0d loads, expected 26", load_log.size()); end
      repeat (6) tick();
      rst = 1'b1;
      tick();
      n_checks++; if (tap_value !== 9'd0 || tap_load !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_tap: tap=%0d load=%0b, expected 0/0", tap_value, tap_load); end
      n_checks++; if (busy !== 1'b0 || locked !== 1'b0 || fail !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_flags: busy=%0b locked=%0b fail=%0b, expected 0/0/0", busy, locked, fail); end
      n_checks++; if (eye_start !== 9'd0 || eye_width !== 8'd0 || err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_mid_eye: start=%0d width=%0d err=%0d, expected 0/0/0", eye_start, eye_width, err_count); end
      rst = 1'b0;
      tick();
      start_train();
      wait_train();
      n_checks++; if (load_log.size() !== 65 || load_log[0] !== 0) begin n_fail++; $display("[TB] FAIL resweep_loads: got %0d loads, expected 65 from tap 0", load_log.size()); end
      n_checks++; if (locked !== 1'b1 || tap_value !== 9'd252) begin n_fail++; $display("[TB] FAIL resweep_lock: locked=%0b tap=%0d, expected 1/252", locked, tap_value); end
   endtask

   initial begin
      test_reset();
      test_clean_sweep();
      test_single_window();
      test_two_windows();
      test_no_window();
      test_locked_errors();
      test_rst_mid_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/zmod_rx_align.md
# zmod_rx_align

Receive-side eye-training controller for the ZMOD LVDS loopback link. It sweeps a shared input-delay tap across the 4-lane receive path and checks the incrementing nibble pattern at each tap. It then loads the centre of the widest passing window and monitors the link while locked. It sits in the receive clock domain, between the IDDRE1 capture registers (data source) and the IDELAYE3 tap inputs (configured resource).

## Interface
- TAP_W, 9: width of the delay tap value.
- TAP_MAX, 511: highest tap swept.
- TAP_STEP, 8: tap increment per sweep point.
- SETTLE_CYC, 16: cycles waited after each tap load before checking.
- CHECK_LEN, 256: pattern comparisons per sweep point.
- MIN_WIDTH, 4: minimum passing sweep points for success.
- ERR_THRESH, 16: locked-mode error count that forces retraining.

Ports:
- clk  in  1  receive clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins training.
- rx_data  in  4  captured nibble, one per clk.
- tap_value  out  TAP_W  delay tap to load.
- tap_load  out  1  one-cycle load strobe.
- busy  out  1  training in progress.
- locked  out  1  centred tap loaded, link passing.
- fail  out  1  training found no valid window.
- eye_start  out  TAP_W  first tap of chosen window.
- eye_width  out  8  chosen window width in sweep points.
- err_count  out  16  locked-mode mismatch count.

## Operation
- States: IDLE, LOAD, SETTLE, CHECK, NEXT, CENTER, LOCKED, FAIL.
- IDLE: on start go to LOAD with tap = 0, and clear window trackers, eye outputs and err_count.
- LOAD: assert tap_load for 1 cycle with tap_value = current tap, then go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to CHECK.
- CHECK, first cycle: capture prev = rx_data with no compare.
- CHECK, next CHECK_LEN cycles: mismatch if rx_data != (prev+1) mod 16; prev updates every cycle. The point passes only with zero mismatches.
- NEXT, pass: if cur_len = 0, set cur_start = tap; then increment cur_len.
- NEXT, fail: close the window. If cur_len > best_len (strictly greater, so the earlier window wins ties), copy cur to best. Then clear cur_len.
- NEXT, then: if tap + TAP_STEP <= TAP_MAX, advance tap and go to LOAD. Otherwise close the window as above and go to CENTER.
- CENTER, best_len >= MIN_WIDTH: tap = best_start + (((best_len−1)·TAP_STEP) >> 1). Pulse tap_load, set eye_start/eye_width, go to LOCKED.
- CENTER, otherwise: tap = 0. Pulse tap_load, set eye_width = best_len, go to FAIL.
- LOCKED: keep comparing rx_data against prev+1. Each mismatch increments err_count, which saturates at 0xFFFF. When err_count reaches ERR_THRESH, clear locked and retrain (go to LOAD, tap 0, trackers cleared).
- Flags: busy = 1 in LOAD through CENTER; locked = 1 only in LOCKED; fail = 1 only in FAIL.
- start in LOCKED or FAIL restarts training. start while busy is ignored.

## Timing
- Reset values: tap_value 0, tap_load 0, busy 0, locked 0, fail 0, eye_start 0, eye_width 0, err_count 0. State is IDLE.
- rst mid-sweep returns to reset values on the next edge, and no tap_load is issued.
- Cycles per sweep point: 1 (LOAD) + SETTLE_CYC + 1 + CHECK_LEN + 1 (NEXT). With defaults that is 275 cycles.
- Sweep points: TAP_MAX/TAP_STEP + 1 (64 with defaults). Full training with defaults is 64·275 + 1 cycles.
- start to first tap_load: 1 cycle.
- tap_value changes only in a tap_load cycle and stays stable between loads.
- Flags are registered and update on the cycle the FSM enters the state.
- Mismatch detection to err_count increment: 1 cycle.
- Arithmetic: window centre is computed at TAP_W+8 bits, then truncated. The result is always ≤ TAP_MAX.

## Configuration
- ZMOD_ALIGN_ERRCNT_EN defined: LOCKED-mode error counting and automatic retraining at ERR_THRESH are active.
- Not defined: err_count is tied to 0 and LOCKED compares nothing. Only rst or start leaves LOCKED.

## Test plan
- Clean pattern at every tap, defaults, pulse start → tap_load on taps 0,8,…,504. Final load is tap 252, eye_start 0, eye_width 64, locked = 1.
- Pattern corrupted except taps 128–256 → eye_start 128, eye_width 17, final tap 192, locked.
- Two 8-point windows at 64–120 and 320–376 → first window chosen, final tap 92.
- Corruption at every tap → fail = 1, eye_width 0, final tap_load with tap 0, locked = 0.
- Locked, then inject 16 mismatches → err_count reaches 16, locked drops the next cycle, tap_load with tap 0 follows. Without the macro: locked stays 1 and err_count stays 0.
- rst asserted mid-CHECK at tap 200 → all outputs reset the next cycle. A second start sweeps again from tap 0.
